pe_adder_tree_acc: RTL and testbench

Parametrised successor to the processing element's fixed 16-input partial-product adder. It sums `N_IN` signed partial products through a fully pipelined binary adder tree. A shift-accumulate stage then either passes each tree sum straight through or accumulates shifted tree sums over a multi-beat group, as needed for bit-serial, higher-precision operands. The block sits between the PE multiplier array and the PE output/writeback logic, and is a streaming block with no backpressure.

---
 rtl/pe_adder_pkg.sv | 55 +++++
 rtl/pe_adder_tree_stage.sv | 82 ++++++++
 rtl/pe_adder_tree_acc.sv | 160 ++++++++++++++++
 tb/tb_pe_adder_tree_acc.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_adder_pkg.sv
// Shared definitions for the PE partial-product adder tree and accumulator.
//   - PE_MODE_PASS / PE_MODE_ACC: per-beat mode encoding on i_mode.
//   - tree_depth(): number of registered levels for a given input count.
//   - tree_off():   bit offset of a tree level inside the flattened level bus.
//   - sat_to_w():   signed saturation of a wide value to a narrower width.
package pe_adder_pkg;

    localparam logic PE_MODE_PASS = 1'b0;
    localparam logic PE_MODE_ACC  = 1'b1;

    // Widest value sat_to_w() can clamp. The accumulator's raw sum is
    // ACC_W + 2^SHIFT_W + 1 bits wide and must fit in this.
    localparam int unsigned SAT_MAX_W = 128;

    typedef struct packed {
        logic                 sat;
        logic [SAT_MAX_W-1:0] val;
    } sat_res_t;

    function automatic int unsigned tree_depth(input int unsigned n);
        return $clog2(n);
    endfunction

    // Level 0 is the raw input vector; level j holds (n_in >> j) sums of in_w + j bits.
    function automatic int unsigned tree_off(input int unsigned n_in, input int unsigned in_w,
                                             input int unsigned lvl);
        int unsigned off;
        off = 0;
        for (int unsigned i = 0; i < lvl; i++) begin
            off += (n_in >> i) * (in_w + i);
        end
        return off;
    endfunction

    // Clamp a signed value into the signed range of w bits (w >= 2).
    function automatic sat_res_t sat_to_w(input logic signed [SAT_MAX_W-1:0] val,
                                          input int unsigned w);
        logic signed [SAT_MAX_W-1:0] max_v;
        logic signed [SAT_MAX_W-1:0] min_v;
        sat_res_t                    res;
        max_v   = (SAT_MAX_W'(1) <<< (w - 1)) - SAT_MAX_W'(1);
        min_v   = ~max_v;
        res.sat = 1'b0;
        res.val = val;
        if (val > max_v) begin
            res.sat = 1'b1;
            res.val = max_v;
        end else if (val < min_v) begin
            res.sat = 1'b1;
            res.val = min_v;
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_adder_tree_stage.sv
// One registered level of the partial-product adder tree.
// Pairs adjacent signed inputs and registers their sign-extended sums, one bit wider than
// the inputs so the level cannot overflow. The beat sideband is delayed alongside.
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_sum / o_sum           N_IN packed inputs of IN_W bits / N_IN/2 sums of IN_W+1 bits
//   i_valid, i_mode, i_shift, i_first, i_last  sideband in; o_* same sideband, one cycle later
module pe_adder_tree_stage
    import pe_adder_pkg::*;
#(
    parameter int unsigned N_IN    = 2,
    parameter int unsigned IN_W    = 8,
    parameter int unsigned SHIFT_W = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_valid,
    input  logic                             i_mode,
    input  logic [SHIFT_W-1:0]               i_shift,
    input  logic                             i_first,
    input  logic                             i_last,
    input  logic [N_IN*IN_W-1:0]             i_sum,
    output logic                             o_valid,
    output logic                             o_mode,
    output logic [SHIFT_W-1:0]               o_shift,
    output logic                             o_first,
    output logic                             o_last,
    output logic [(N_IN/2)*(IN_W+1)-1:0]     o_sum
);

    localparam int unsigned N_OUT = N_IN / 2;
    localparam int unsigned OUT_W = IN_W + 1;

    logic [N_OUT*OUT_W-1:0] sum_d, sum_q;
    logic                   valid_d, valid_q;
    logic                   mode_d, mode_q;
    logic [SHIFT_W-1:0]     shift_d, shift_q;
    logic                   first_d, first_q;
    logic                   last_d, last_q;
    logic [IN_W-1:0]        op_a, op_b;

    always_comb begin
        sum_d = '0;
        op_a  = '0;
        op_b  = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            op_a = i_sum[(2*k)*IN_W +: IN_W];
            op_b = i_sum[(2*k+1)*IN_W +: IN_W];
            sum_d[k*OUT_W +: OUT_W] = {op_a[IN_W-1], op_a} + {op_b[IN_W-1], op_b};
        end
        valid_d = i_valid;
        mode_d  = i_mode;
        shift_d = i_shift;
        first_d = i_first;
        last_d  = i_last;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
            mode_q  <= 1'b0;
            shift_q <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            valid_q <= valid_d;
            mode_q  <= mode_d;
            shift_q <= shift_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign o_sum   = sum_q;
    assign o_valid = valid_q;
    assign o_mode  = mode_q;
    assign o_shift = shift_q;
    assign o_first = first_q;
    assign o_last  = last_q;

endmodule

// File: rtl/pe_adder_tree_acc.sv
// PE partial-product adder: pipelined binary adder tree followed by a shift-accumulate stage.
// Each beat's tree sum is shifted left by i_shift; PASS beats emit the saturated result
// directly, ACC beats build up a group that is emitted on its last beat.
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_valid        beat present; i_prod holds N_IN packed signed products of IN_W bits
//   i_mode         PE_MODE_PASS / PE_MODE_ACC
//   i_shift        left shift for this beat's tree sum
//   i_first/i_last ACC group delimiters
//   o_valid        single-cycle result strobe; o_sum / o_sat hold between strobes
// Latency is tree_depth(N_IN) + 1 cycles; one beat per cycle, no backpressure.
// ACC_W + 2^SHIFT_W + 1 must not exceed SAT_MAX_W.
module pe_adder_tree_acc
    import pe_adder_pkg::*;
#(
    parameter int unsigned N_IN    = 16,
    parameter int unsigned IN_W    = 21,
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned SHIFT_W = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    input  logic [N_IN*IN_W-1:0]    i_prod,
    input  logic                    i_mode,
    input  logic [SHIFT_W-1:0]      i_shift,
    input  logic                    i_first,
    input  logic                    i_last,
    output logic                    o_valid,
    output logic [ACC_W-1:0]        o_sum,
    output logic                    o_sat
);

    localparam int unsigned L     = tree_depth(N_IN);
    localparam int unsigned SUM_W = IN_W + L;
    localparam int unsigned T_W   = ACC_W + (1 << SHIFT_W);
    localparam int unsigned R_W   = T_W + 1;
    localparam int unsigned BUS_W = tree_off(N_IN, IN_W, L + 1);
    localparam int unsigned OFF_L = tree_off(N_IN, IN_W, L);

    // All tree levels flattened into one bus; level 0 is the raw input.
    logic [BUS_W-1:0]           tree_bus;
    logic [L:0]                 sb_valid, sb_mode, sb_first, sb_last;
    logic [(L+1)*SHIFT_W-1:0]   sb_shift;

    assign tree_bus[N_IN*IN_W-1:0]  = i_prod;
    assign sb_valid[0]              = i_valid;
    assign sb_mode[0]               = i_mode;
    assign sb_first[0]              = i_first;
    assign sb_last[0]               = i_last;
    assign sb_shift[SHIFT_W-1:0]    = i_shift;

    for (genvar j = 1; j <= L; j++) begin : g_lvl
        localparam int unsigned NJ      = N_IN >> (j - 1);
        localparam int unsigned WJ      = IN_W + j - 1;
        localparam int unsigned OFF_IN  = tree_off(N_IN, IN_W, j - 1);
        localparam int unsigned OFF_OUT = tree_off(N_IN, IN_W, j);

        pe_adder_tree_stage #(
            .N_IN    (NJ),
            .IN_W    (WJ),
            .SHIFT_W (SHIFT_W)
        ) u_stage (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_valid (sb_valid[j-1]),
            .i_mode  (sb_mode[j-1]),
            .i_shift (sb_shift[(j-1)*SHIFT_W +: SHIFT_W]),
            .i_first (sb_first[j-1]),
            .i_last  (sb_last[j-1]),
            .i_sum   (tree_bus[OFF_IN +: NJ*WJ]),
            .o_valid (sb_valid[j]),
            .o_mode  (sb_mode[j]),
            .o_shift (sb_shift[j*SHIFT_W +: SHIFT_W]),
            .o_first (sb_first[j]),
            .o_last  (sb_last[j]),
            .o_sum   (tree_bus[OFF_OUT +: (NJ/2)*(WJ+1)])
        );
    end

    logic signed [SUM_W-1:0]    tree_sum;
    logic signed [T_W-1:0]      shifted;
    logic signed [ACC_W-1:0]    base;
    logic signed [R_W-1:0]      r_full;
    sat_res_t                   res;
    logic                       is_acc, cont, grp_sat_nx;

    logic signed [ACC_W-1:0]    acc_d, acc_q;
    logic                       open_d, open_q;
    logic                       grp_sat_d, grp_sat_q;
    logic                       out_valid_d, out_valid_q;
    logic [ACC_W-1:0]           out_sum_d, out_sum_q;
    logic                       out_sat_d, out_sat_q;

    assign tree_sum = tree_bus[OFF_L +: SUM_W];

    // Clamped result always fits in ACC_W; the upper bits only feed this reduction.
    logic unused_sat_hi;
    assign unused_sat_hi = ^res.val[SAT_MAX_W-1:ACC_W];

    always_comb begin
        is_acc  = (sb_mode[L] == PE_MODE_ACC);
        // An ACC beat without first on a closed group also starts a fresh group.
        cont    = is_acc && !sb_first[L] && open_q;
        shifted = T_W'(tree_sum) <<< sb_shift[L*SHIFT_W +: SHIFT_W];
        base    = cont ? acc_q : '0;
        r_full  = R_W'(base) + R_W'(shifted);
        res     = sat_to_w(SAT_MAX_W'(r_full), ACC_W);
        grp_sat_nx = (cont ? grp_sat_q : 1'b0) | res.sat;

        acc_d       = acc_q;
        open_d      = open_q;
        grp_sat_d   = grp_sat_q;
        out_valid_d = 1'b0;
        out_sum_d   = out_sum_q;
        out_sat_d   = out_sat_q;

        if (sb_valid[L]) begin
            if (!is_acc) begin
                // PASS leaves any open group untouched.
                out_valid_d = 1'b1;
                out_sum_d   = res.val[ACC_W-1:0];
                out_sat_d   = res.sat;
            end else if (sb_last[L]) begin
                out_valid_d = 1'b1;
                out_sum_d   = res.val[ACC_W-1:0];
                out_sat_d   = grp_sat_nx;
                acc_d       = '0;
                open_d      = 1'b0;
                grp_sat_d   = 1'b0;
            end else begin
                acc_d       = res.val[ACC_W-1:0];
                open_d      = 1'b1;
                grp_sat_d   = grp_sat_nx;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q       <= '0;
            open_q      <= 1'b0;
            grp_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            open_q      <= open_d;
            grp_sat_q   <= grp_sat_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign o_valid = out_valid_q;
    assign o_sum   = out_sum_q;
    assign o_sat   = out_sat_q;

endmodule

// File: tb/tb_pe_adder_tree_acc.sv
// Bench for pe_adder_tree_acc: a 16-input and a 4-input instance share one stimulus stream
// (the 4-input one sees products 0..3). A reference model of the group/saturation rules
// predicts every output cycle of both instances; directed cases add fixed expectations.
module tb_pe_adder_tree_acc;

    localparam int IN_W    = 21;
    localparam int ACC_W   = 32;
    localparam int SHIFT_W = 4;
    localparam int L16     = 4;
    localparam int L4      = 2;
    localparam longint MAXV = (64'sd1 <<< 31) - 1;
    localparam longint MINV = -(64'sd1 <<< 31);

    typedef struct {
        int     n;
        longint s16;
        longint s4;
        bit     mode;
        int     shift;
        bit     first;
        bit     last;
    } beat_t;

    typedef struct {
        int     cyc;
        longint sum;
        bit     sat;
    } obs_t;

    logic                   clk = 1'b0;
    logic                   i_rst, i_valid, i_mode, i_first, i_last;
    logic [SHIFT_W-1:0]     i_shift;
    logic [16*IN_W-1:0]     prod16;
    logic [4*IN_W-1:0]      prod4;
    logic                   v16, sat16, v4, sat4;
    logic [ACC_W-1:0]       sum16, sum4;

    int     n_checks = 0;
    int     n_errors = 0;
    int     cyc = 0;
    bit     rst_seen = 1'b0;
    bit     mon_en = 1'b0;
    int     p[16];
    beat_t  beats[$];
    obs_t   obs16[$];
    int     rd[2];
    longint acc_m[2];
    bit     open_m[2];
    bit     gs_m[2];
    longint last_sum[2];
    bit     last_sat[2];

    pe_adder_tree_acc #(.N_IN(16), .IN_W(IN_W), .ACC_W(ACC_W), .SHIFT_W(SHIFT_W)) u_dut16 (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_prod(prod16), .i_mode(i_mode),
        .i_shift(i_shift), .i_first(i_first), .i_last(i_last),
        .o_valid(v16), .o_sum(sum16), .o_sat(sat16)
    );

    pe_adder_tree_acc #(.N_IN(4), .IN_W(IN_W), .ACC_W(ACC_W), .SHIFT_W(SHIFT_W)) u_dut4 (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_prod(prod4), .i_mode(i_mode),
        .i_shift(i_shift), .i_first(i_first), .i_last(i_last),
        .o_valid(v4), .o_sum(sum4), .o_sat(sat4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= i_rst;
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint sat_acc(input longint r, output bit s);
        s = 1'b0;
        if (r > MAXV) begin
            s = 1'b1;
            return MAXV;
        end
        if (r < MINV) begin
            s = 1'b1;
            return MINV;
        end
        return r;
    endfunction

    // Reference model: applies a beat when it is due at the output of instance w.
    task automatic mon_check(input int w, input logic v, input logic [ACC_W-1:0] s,
                             input logic st);
        bit     ev, esat, ts;
        longint es, sv, tsum, t;
        int     lat;
        string  nm;
        beat_t  b;
        nm   = (w == 0) ? "n16" : "n4";
        lat  = (w == 0) ? L16 + 1 : L4 + 1;
        ev   = 1'b0;
        es   = last_sum[w];
        esat = last_sat[w];
        if (rst_seen) begin
            while (rd[w] < beats.size() && beats[rd[w]].n < cyc) rd[w]++;
            acc_m[w]  = 0;
            open_m[w] = 1'b0;
            gs_m[w]   = 1'b0;
            es        = 0;
            esat      = 1'b0;
        end else if (rd[w] < beats.size() && beats[rd[w]].n + lat == cyc) begin
            b = beats[rd[w]];
            rd[w]++;
            tsum = (w == 0) ? b.s16 : b.s4;
            t    = tsum * (longint'(1) << b.shift);
            if (!b.mode) begin
                es   = sat_acc(t, ts);
                esat = ts;
                ev   = 1'b1;
            end else begin
                if (b.first || !open_m[w]) begin
                    acc_m[w] = 0;
                    gs_m[w]  = 1'b0;
                end
                acc_m[w] = sat_acc(acc_m[w] + t, ts);
                gs_m[w]  = gs_m[w] | ts;
                if (b.last) begin
                    ev        = 1'b1;
                    es        = acc_m[w];
                    esat      = gs_m[w];
                    acc_m[w]  = 0;
                    open_m[w] = 1'b0;
                    gs_m[w]   = 1'b0;
                end else begin
                    open_m[w] = 1'b1;
                end
            end
        end
        last_sum[w] = es;
        last_sat[w] = esat;
        sv = $signed(s);
        check_eq({nm, "_valid"}, longint'(v), longint'(ev));
        check_eq({nm, "_sum"}, sv, es);
        check_eq({nm, "_sat"}, longint'(st), longint'(esat));
        if (w == 0 && v) obs16.push_back('{cyc, sv, st});
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_check(0, v16, sum16, sat16);
            mon_check(1, v4, sum4, sat4);
        end
    end

    task automatic drive_beat(input bit v, input bit mode, input int shift, input bit first,
                              input bit last);
        beat_t b;
        longint s16, s4;
        s16 = 0;
        s4  = 0;
        for (int k = 0; k < 16; k++) begin
            prod16[k*IN_W +: IN_W] = p[k][IN_W-1:0];
            s16 += p[k];
            if (k < 4) begin
                prod4[k*IN_W +: IN_W] = p[k][IN_W-1:0];
                s4 += p[k];
            end
        end
        i_valid = v;
        i_mode  = mode;
        i_shift = shift[SHIFT_W-1:0];
        i_first = first;
        i_last  = last;
        if (v) begin
            b = '{cyc, s16, s4, mode, shift, first, last};
            beats.push_back(b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_beat(1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic reset_pulse();
        i_rst   = 1'b1;
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic set_all(input int val);
        for (int k = 0; k < 16; k++) p[k] = val;
    endtask

    task automatic set_one(input int val);
        set_all(0);
        p[0] = val;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_mode  = 1'b0;
        i_first = 1'b0;
        i_last  = 1'b0;
        i_shift = '0;
        prod16  = '0;
        prod4   = '0;
        set_all(0);
        for (int w = 0; w < 2; w++) begin
            rd[w] = 0; acc_m[w] = 0; open_m[w] = 0; gs_m[w] = 0; last_sum[w] = 0;
            last_sat[w] = 0;
        end
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        idle(2);

        // PASS, all ones: 16 after 5 cycles.
        obs16.delete();
        set_all(1);
        n0 = cyc;
        drive_beat(1'b1, 1'b0, 0, 1'b0, 1'b0);
        idle(8);
        check_eq("pass1_count", obs16.size(), 1);
        if (obs16.size() >= 1) begin
            check_eq("pass1_lat", obs16[0].cyc - n0, 5);
            check_eq("pass1_sum", obs16[0].sum, 16);
            check_eq("pass1_sat", obs16[0].sat, 0);
        end

        // PASS most-negative inputs, unshifted then shifted into saturation.
        obs16.delete();
        set_all(-1048576);
        drive_beat(1'b1, 1'b0, 0, 1'b0, 1'b0);
        drive_beat(1'b1, 1'b0, 15, 1'b0, 1'b0);
        idle(8);
        check_eq("neg_count", obs16.size(), 2);
        if (obs16.size() >= 2) begin
            check_eq("neg_sum", obs16[0].sum, -16777216);
            check_eq("neg_sat", obs16[0].sat, 0);
            check_eq("negsh_sum", obs16[1].sum, MINV);
            check_eq("negsh_sat", obs16[1].sat, 1);
        end

        // Four-beat ACC group with shifts 0..3: 240, 8 cycles after beat 0.
        obs16.delete();
        set_all(1);
        n0 = cyc;
        for (int i = 0; i < 4; i++) drive_beat(1'b1, 1'b1, i, i == 0, i == 3);
        idle(10);
        check_eq("grp4_count", obs16.size(), 1);
        if (obs16.size() >= 1) begin
            check_eq("grp4_lat", obs16[0].cyc - n0, 8);
            check_eq("grp4_sum", obs16[0].sum, 240);
        end

        // Group restarted by first: only the single-beat group's 7 appears.
        obs16.delete();
        set_all(1);
        drive_beat(1'b1, 1'b1, 0, 1'b1, 1'b0);
        drive_beat(1'b1, 1'b1, 0, 1'b0, 1'b0);
        set_one(7);
        drive_beat(1'b1, 1'b1, 0, 1'b1, 1'b1);
        idle(8);
        check_eq("restart_count", obs16.size(), 1);
        if (obs16.size() >= 1) check_eq("restart_sum", obs16[0].sum, 7);

        // PASS inside an open group.
        obs16.delete();
        set_all(1);
        drive_beat(1'b1, 1'b1, 0, 1'b1, 1'b0);
        set_all(3);
        drive_beat(1'b1, 1'b0, 0, 1'b0, 1'b0);
        set_all(1);
        drive_beat(1'b1, 1'b1, 0, 1'b0, 1'b1);
        idle(8);
        check_eq("interleave_count", obs16.size(), 2);
        if (obs16.size() >= 2) begin
            check_eq("interleave_pass", obs16[0].sum, 48);
            check_eq("interleave_grp", obs16[1].sum, 32);
        end

        // Reset with a group open and beats in the tree.
        obs16.delete();
        set_all(1);
        for (int i = 0; i < 6; i++) drive_beat(1'b1, 1'b1, 0, i == 0, 1'b0);
        reset_pulse();
        set_one(5);
        drive_beat(1'b1, 1'b1, 0, 1'b1, 1'b1);
        idle(8);
        check_eq("rst_count", obs16.size(), 1);
        if (obs16.size() >= 1) check_eq("rst_sum", obs16[0].sum, 5);

        // Random stream with bubbles and rare resets.
        for (int it = 0; it < 700; it++) begin
            int r, sh;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                reset_pulse();
            end else if (r < 27) begin
                idle(1);
            end else begin
                for (int k = 0; k < 16; k++) begin
                    if ($urandom_range(0, 1) == 0) p[k] = int'($urandom_range(0, 2097151)) - 1048576;
                    else p[k] = int'($urandom_range(0, 16)) - 8;
                end
                sh = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
                drive_beat(1'b1, $urandom_range(0, 1) == 1, sh, $urandom_range(0, 3) == 0,
                           $urandom_range(0, 2) == 0);
            end
        end
        idle(12);
        check_eq("drain_n16", rd[0], beats.size());
        check_eq("drain_n4", rd[1], beats.size());

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
